i2c_slave_top: RTL and testbench

- I2C target (slave) peripheral; the responding end of the bus driven by the team's I2C master.
- Sits on the same Avalon-style register bus as the master and exposes the same register style: a registered read port and a level interrupt.
- Responds to one programmable 7-bit address, receives write bytes into an RX holding register, and transmits read bytes from a TX holding register.
- No clock stretching: it never drives SCL.

---
 rtl/i2c_slave_top.sv | 353 +++++++++++++++++++++++++++++++++++
 tb/tb_i2c_slave_top.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_top.sv
// ---------------------------------------------------------------------------
// i2c_slave_top
//
// I2C target peripheral. It answers one programmable 7-bit address, collects
// write bytes into an RX holding register and returns read bytes from a TX
// holding register. It never drives SCL, so there is no clock stretching.
//
// Ports
//   clk_i, rstn_i        system clock; synchronous reset, asserted high
//   avl_addr/avl_wdata   register bus address (select = [5:2]) and write data
//   avl_write/chipsel    write strobe and select (chipsel alone = read)
//   avl_rdata            registered read data, valid one cycle after chipsel
//   interrupt_o          registered IRQ flag gated by IEN
//   scl_pad_i/sda_pad_i  bus lines
//   sda_pad_o            always 0 (open drain)
//   sda_padoen_o         0 pulls SDA low, 1 releases it
//
// Register map: 0x00 ADDR, 0x04 CTRL {EN,IEN}, 0x08 RX, 0x0C STATUS,
// 0x10 TX (write only), 0x14 CMD {clear OVR/UNR, IACK}.
// STATUS = {RW, BUSY, AAS, TXE, RXV, OVR, UNR, IRQ}.
// ---------------------------------------------------------------------------
module i2c_slave_top #(
    parameter logic [6:0] ADDR_RST = 7'h00
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [7:0]  avl_addr,
    input  logic [31:0] avl_wdata,
    input  logic        avl_write,
    input  logic        avl_chipsel,
    output logic [31:0] avl_rdata,
    output logic        interrupt_o,
    input  logic        scl_pad_i,
    input  logic        sda_pad_i,
    output logic        sda_pad_o,
    output logic        sda_padoen_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX_DATA,
        S_RX_ACK, S_TX_DATA, S_TX_ACK, S_WAIT_STOP
    } state_t;

    localparam logic [3:0] REG_ADDR   = 4'd0;
    localparam logic [3:0] REG_CTRL   = 4'd1;
    localparam logic [3:0] REG_RX     = 4'd2;
    localparam logic [3:0] REG_STATUS = 4'd3;
    localparam logic [3:0] REG_TX     = 4'd4;
    localparam logic [3:0] REG_CMD    = 4'd5;

    // Line conditioning
    logic r_scl_s1, r_scl_s2, r_scl_d, r_scl_rise, r_scl_fall;
    logic r_sda_s1, r_sda_s2, r_sda_d, r_sda_rise, r_sda_fall;

    // Protocol state
    state_t     r_state, w_state_nxt;
    logic [2:0] r_cnt;
    logic [7:0] r_shift;
    logic       r_sda_oen, r_ack_ok;

    // Registers
    logic [6:0]  r_addr;
    logic        r_en, r_ien;
    logic [7:0]  r_rx, r_tx;
    logic        r_rw, r_busy, r_aas, r_txe, r_rxv, r_ovr, r_unr, r_irq;
    logic [31:0] r_rdata;
    logic        r_irq_out;

    // Combinational controls
    logic        w_start, w_stop;
    logic        w_oen_nxt, w_cnt_clr, w_cnt_inc;
    logic        w_shift_in, w_shift_out, w_tx_load;
    logic        w_addr_hit, w_rx_accept, w_rx_ovr, w_ack_ok_set;
    logic [7:0]  w_rx_byte, w_load_byte, w_status;
    logic [3:0]  w_sel;
    logic        w_rd, w_wr;
    logic [31:0] w_rd_mux;
    logic        w_unused;

    // Byte being assembled, including the bit sampled on this SCL rise.
    assign w_rx_byte   = {r_shift[6:0], r_sda_d};
    // An empty TX register sends all ones (released line) and flags underrun.
    assign w_load_byte = r_txe ? 8'hFF : r_tx;

    // r_scl_d/r_sda_d are the synchronized levels aligned with the edge
    // pulses, so START/STOP qualify against the SCL level of the same cycle.
    assign w_start = r_sda_fall & r_scl_d;
    assign w_stop  = r_sda_rise & r_scl_d;

    assign w_sel    = avl_addr[5:2];
    assign w_rd     = avl_chipsel & ~avl_write;
    assign w_wr     = avl_chipsel & avl_write;
    assign w_unused = ^{avl_addr[7:6], avl_addr[1:0], avl_wdata[31:8]};

    assign w_status = {r_rw, r_busy, r_aas, r_txe, r_rxv, r_ovr, r_unr, r_irq};

    // 2-flop synchronizer followed by a registered edge detector: a pad
    // change shows up as an edge pulse three clocks later.
    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            r_scl_s1   <= 1'b1;
            r_scl_s2   <= 1'b1;
            r_scl_d    <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_sda_s1   <= 1'b1;
            r_sda_s2   <= 1'b1;
            r_sda_d    <= 1'b1;
            r_sda_rise <= 1'b0;
            r_sda_fall <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, so the synchronizer chain really is 2 deep.
            r_scl_s1   <= scl_pad_i;
            r_scl_s2   <= r_scl_s1;
            r_scl_d    <= r_scl_s2;
            r_scl_rise <= r_scl_s2 & ~r_scl_d;
            r_scl_fall <= ~r_scl_s2 & r_scl_d;
            r_sda_s1   <= sda_pad_i;
            r_sda_s2   <= r_sda_s1;
            r_sda_d    <= r_sda_s2;
            r_sda_rise <= r_sda_s2 & ~r_sda_d;
            r_sda_fall <= ~r_sda_s2 & r_sda_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rstn_i) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves a signal unassigned and infers a latch.
        w_state_nxt  = r_state;
        w_oen_nxt    = r_sda_oen;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_shift_in   = 1'b0;
        w_shift_out  = 1'b0;
        w_tx_load    = 1'b0;
        w_addr_hit   = 1'b0;
        w_rx_accept  = 1'b0;
        w_rx_ovr     = 1'b0;
        w_ack_ok_set = 1'b0;

        if (!r_en) begin
            w_state_nxt = S_IDLE;
            w_oen_nxt   = 1'b1;
        end else if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_oen_nxt   = 1'b1;
        end else if (w_start) begin
            w_state_nxt = S_ADDR;
            w_cnt_clr   = 1'b1;
            w_oen_nxt   = 1'b1;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (r_scl_rise) begin
                        w_shift_in = 1'b1;
                        if (r_cnt == 3'd7) begin
                            if (w_rx_byte[7:1] == r_addr) begin
                                w_addr_hit  = 1'b1;
                                w_state_nxt = S_ADDR_ACK;
                            end else begin
                                w_state_nxt = S_WAIT_STOP;
                            end
                        end else begin
                            w_cnt_inc = 1'b1;
                        end
                    end
                end
                // SDA is still released on entry; the first fall starts the
                // ACK and the second one ends it.
                S_ADDR_ACK: begin
                    if (r_scl_fall) begin
                        if (r_sda_oen) begin
                            w_oen_nxt = 1'b0;
                        end else if (r_rw) begin
                            w_tx_load   = 1'b1;
                            w_oen_nxt   = w_load_byte[7];
                            w_cnt_clr   = 1'b1;
                            w_state_nxt = S_TX_DATA;
                        end else begin
                            w_oen_nxt   = 1'b1;
                            w_cnt_clr   = 1'b1;
                            w_state_nxt = S_RX_DATA;
                        end
                    end
                end
                S_RX_DATA: begin
                    if (r_scl_rise) begin
                        w_shift_in = 1'b1;
                        if (r_cnt == 3'd7) begin
                            if (!r_rxv) begin
                                w_rx_accept = 1'b1;
                                w_state_nxt = S_RX_ACK;
                            end else begin
                                w_rx_ovr    = 1'b1;
                                w_state_nxt = S_WAIT_STOP;
                            end
                        end else begin
                            w_cnt_inc = 1'b1;
                        end
                    end
                end
                S_RX_ACK: begin
                    if (r_scl_fall) begin
                        if (r_sda_oen) begin
                            w_oen_nxt = 1'b0;
                        end else begin
                            w_oen_nxt   = 1'b1;
                            w_cnt_clr   = 1'b1;
                            w_state_nxt = S_RX_DATA;
                        end
                    end
                end
                // Bit 7 was put on the line by the load; falls 1..7 drive
                // bits 6..0 and the 8th fall hands SDA back for the ACK.
                S_TX_DATA: begin
                    if (r_scl_fall) begin
                        if (r_cnt == 3'd7) begin
                            w_oen_nxt   = 1'b1;
                            w_state_nxt = S_TX_ACK;
                        end else begin
                            w_oen_nxt   = r_shift[7];
                            w_shift_out = 1'b1;
                            w_cnt_inc   = 1'b1;
                        end
                    end
                end
                S_TX_ACK: begin
                    if (r_scl_rise) begin
                        if (!r_sda_d) w_ack_ok_set = 1'b1;
                        else          w_state_nxt  = S_WAIT_STOP;
                    end else if (r_scl_fall && r_ack_ok) begin
                        w_tx_load   = 1'b1;
                        w_oen_nxt   = w_load_byte[7];
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = S_TX_DATA;
                    end
                end
                S_WAIT_STOP: w_oen_nxt = 1'b1;
                default:     w_oen_nxt = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_rd_mux = 32'h0;
        case (w_sel)
            REG_ADDR:   w_rd_mux = {25'h0, r_addr};
            REG_CTRL:   w_rd_mux = {24'h0, r_en, r_ien, 6'h0};
            REG_RX:     w_rd_mux = {24'h0, r_rx};
            REG_STATUS: w_rd_mux = {24'h0, w_status};
            default:    w_rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            r_cnt     <= 3'd0;
            r_shift   <= 8'h00;
            r_sda_oen <= 1'b1;
            r_ack_ok  <= 1'b0;
            r_addr    <= ADDR_RST;
            r_en      <= 1'b0;
            r_ien     <= 1'b0;
            r_rx      <= 8'h00;
            r_tx      <= 8'h00;
            r_rw      <= 1'b0;
            r_busy    <= 1'b0;
            r_aas     <= 1'b0;
            r_txe     <= 1'b1;
            r_rxv     <= 1'b0;
            r_ovr     <= 1'b0;
            r_unr     <= 1'b0;
            r_irq     <= 1'b0;
            r_rdata   <= 32'h0;
            r_irq_out <= 1'b0;
        end else begin
            r_sda_oen <= w_oen_nxt;

            if (w_cnt_clr)      r_cnt <= 3'd0;
            else if (w_cnt_inc) r_cnt <= r_cnt + 3'd1;

            if (w_tx_load)        r_shift <= {w_load_byte[6:0], 1'b1};
            else if (w_shift_in)  r_shift <= w_rx_byte;
            else if (w_shift_out) r_shift <= {r_shift[6:0], 1'b1};

            if (w_tx_load)         r_ack_ok <= 1'b0;
            else if (w_ack_ok_set) r_ack_ok <= 1'b1;

            if (w_start)     r_busy <= 1'b1;
            else if (w_stop) r_busy <= 1'b0;

            if (w_stop)          r_aas <= 1'b0;
            else if (w_addr_hit) r_aas <= 1'b1;

            if (w_addr_hit) r_rw <= w_rx_byte[0];

            // Bus-side clears come first so that a line event in the same
            // cycle overrides them (new byte keeps RXV, new IRQ survives IACK).
            if (w_rd && w_sel == REG_RX) r_rxv <= 1'b0;
            if (w_wr && w_sel == REG_CMD) begin
                if (avl_wdata[0]) r_irq <= 1'b0;
                if (avl_wdata[1]) begin
                    r_ovr <= 1'b0;
                    r_unr <= 1'b0;
                end
            end

            if (w_rx_accept) begin
                r_rx  <= w_rx_byte;
                r_rxv <= 1'b1;
            end
            if (w_rx_ovr) r_ovr <= 1'b1;
            if (w_tx_load) begin
                if (r_txe) r_unr <= 1'b1;
                else       r_txe <= 1'b1;
            end
            if (w_addr_hit || w_rx_accept || w_ack_ok_set || (w_stop && r_aas))
                r_irq <= 1'b1;

            // Register writes last: a TX write coinciding with a shifter load
            // leaves TX full again after the load consumed the old contents.
            if (w_wr) begin
                case (w_sel)
                    REG_ADDR: r_addr <= avl_wdata[6:0];
                    REG_CTRL: begin
                        r_en  <= avl_wdata[7];
                        r_ien <= avl_wdata[6];
                    end
                    REG_TX: begin
                        r_tx  <= avl_wdata[7:0];
                        r_txe <= 1'b0;
                    end
                    default: ;
                endcase
            end

            if (w_rd) r_rdata <= w_rd_mux;
            r_irq_out <= r_irq & r_ien;
        end
    end

    assign avl_rdata    = r_rdata;
    assign interrupt_o  = r_irq_out;
    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = r_sda_oen;

endmodule

// File: tb/tb_i2c_slave_top.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_top
//
// Self-checking bench for i2c_slave_top. A behavioural I2C master drives the
// pads (SDA is wired-AND with the slave's open-drain output). Register reads
// push their expected value into a scoreboard queue; a monitor pops and
// compares when the registered read data appears.
// ---------------------------------------------------------------------------
module tb_i2c_slave_top;

    localparam int HALF = 12;
    localparam int Q    = 4;

    localparam logic [7:0] A_ADDR   = 8'h00;
    localparam logic [7:0] A_CTRL   = 8'h04;
    localparam logic [7:0] A_RX     = 8'h08;
    localparam logic [7:0] A_STATUS = 8'h0C;
    localparam logic [7:0] A_TX     = 8'h10;
    localparam logic [7:0] A_CMD    = 8'h14;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b1;
    logic [7:0]  avl_addr = 8'h00;
    logic [31:0] avl_wdata = 32'h0;
    logic        avl_write = 1'b0;
    logic        avl_chipsel = 1'b0;
    logic [31:0] avl_rdata;
    logic        interrupt_o;
    logic        scl_pad_i;
    logic        sda_pad_i;
    logic        sda_pad_o;
    logic        sda_padoen_o;

    logic m_scl = 1'b1;
    logic m_sda = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_issued = 1'b0;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct {
        logic [7:0] abyte;
        logic       exp_ack;
        logic [7:0] exp_stat;
    } adr_vec_t;

    reg_vec_t reg_tab[12];
    adr_vec_t adr_tab[4];

    assign scl_pad_i = m_scl;
    assign sda_pad_i = m_sda & (sda_padoen_o | sda_pad_o);

    always #5 clk_i = ~clk_i;

    i2c_slave_top #(.ADDR_RST(7'h00)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .avl_addr     (avl_addr),
        .avl_wdata    (avl_wdata),
        .avl_write    (avl_write),
        .avl_chipsel  (avl_chipsel),
        .avl_rdata    (avl_rdata),
        .interrupt_o  (interrupt_o),
        .scl_pad_i    (scl_pad_i),
        .sda_pad_i    (sda_pad_i),
        .sda_pad_o    (sda_pad_o),
        .sda_padoen_o (sda_padoen_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: read data is registered, so it is compared on the
    // falling edge after the clock that captured the read strobe.
    always @(posedge clk_i) rd_issued <= avl_chipsel & ~avl_write;

    always @(negedge clk_i) begin
        if (rd_issued) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_read", 32'h1, 32'h0);
            end else begin
                check(name_q.pop_front(), avl_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk_i);
        avl_addr    = a;
        avl_wdata   = d;
        avl_write   = 1'b1;
        avl_chipsel = 1'b1;
        @(negedge clk_i);
        avl_write   = 1'b0;
        avl_chipsel = 1'b0;
    endtask

    task automatic reg_read(input logic [7:0] a, input logic [31:0] exp, input string name);
        @(negedge clk_i);
        exp_q.push_back(exp);
        name_q.push_back(name);
        avl_addr    = a;
        avl_write   = 1'b0;
        avl_chipsel = 1'b1;
        @(negedge clk_i);
        avl_chipsel = 1'b0;
    endtask

    // Also serves as repeated START when entered with SCL low.
    task automatic i2c_start();
        wait_cyc(Q);
        m_sda = 1'b1;
        wait_cyc(HALF - Q);
        m_scl = 1'b1;
        wait_cyc(HALF);
        m_sda = 1'b0;
        wait_cyc(HALF);
        m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_cyc(Q);
        m_sda = 1'b0;
        wait_cyc(HALF - Q);
        m_scl = 1'b1;
        wait_cyc(HALF);
        m_sda = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic write_bit(input logic b);
        wait_cyc(Q);
        m_sda = b;
        wait_cyc(HALF - Q);
        m_scl = 1'b1;
        wait_cyc(HALF);
        m_scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        wait_cyc(Q);
        m_sda = 1'b1;
        wait_cyc(HALF - Q);
        m_scl = 1'b1;
        wait_cyc(HALF / 2);
        b = sda_pad_i;
        wait_cyc(HALF / 2);
        m_scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(~ack);
    endtask

    initial begin
        logic       ack;
        logic       bit_v;
        logic [7:0] d;

        reg_tab[0]  = '{1'b1, A_ADDR,  32'hFFFF_FFFF, 32'h0};
        reg_tab[1]  = '{1'b0, A_ADDR,  32'h0,         32'h7F};
        reg_tab[2]  = '{1'b1, A_ADDR,  32'h42,        32'h0};
        reg_tab[3]  = '{1'b0, A_ADDR,  32'h0,         32'h42};
        reg_tab[4]  = '{1'b1, A_CTRL,  32'h3F,        32'h0};
        reg_tab[5]  = '{1'b0, A_CTRL,  32'h0,         32'h00};
        reg_tab[6]  = '{1'b1, A_CTRL,  32'hC0,        32'h0};
        reg_tab[7]  = '{1'b0, A_CTRL,  32'h0,         32'hC0};
        reg_tab[8]  = '{1'b0, A_TX,    32'h0,         32'h00};
        reg_tab[9]  = '{1'b0, A_CMD,   32'h0,         32'h00};
        reg_tab[10] = '{1'b0, 8'h18,   32'h0,         32'h00};
        reg_tab[11] = '{1'b0, 8'hFC,   32'h0,         32'h00};

        // RW status bit keeps the last matched direction (read, from the
        // preceding transaction) until the 0x84 match.
        adr_tab[0] = '{8'h86, 1'b0, 8'h90};
        adr_tab[1] = '{8'hFE, 1'b0, 8'h90};
        adr_tab[2] = '{8'h04, 1'b0, 8'h90};
        adr_tab[3] = '{8'h84, 1'b1, 8'h11};

        // Reset
        wait_cyc(3);
        rstn_i = 1'b0;
        wait_cyc(1);
        check("rst_rdata", avl_rdata, 32'h0);
        check("rst_irq", {31'h0, interrupt_o}, 32'h0);
        check("rst_oen", {31'h0, sda_padoen_o}, 32'h1);
        reg_read(A_STATUS, 32'h10, "rst_status");
        reg_read(A_ADDR,   32'h00, "rst_addr");
        reg_read(A_CTRL,   32'h00, "rst_ctrl");
        reg_read(A_RX,     32'h00, "rst_rx");

        // Register access table
        for (int i = 0; i < 12; i++) begin
            if (reg_tab[i].wr) reg_write(reg_tab[i].addr, reg_tab[i].data);
            else               reg_read(reg_tab[i].addr, reg_tab[i].exp, $sformatf("reg_tab%0d", i));
        end

        // Write transaction
        i2c_start();
        write_byte(8'h84, ack);
        check("wr_addr_ack", {31'h0, ack}, 32'h1);
        write_byte(8'hA5, ack);
        check("wr_data_ack", {31'h0, ack}, 32'h1);
        reg_read(A_STATUS, 32'h79, "wr_status_mid");
        check("wr_irq_out", {31'h0, interrupt_o}, 32'h1);
        i2c_stop();
        wait_cyc(8);
        reg_read(A_STATUS, 32'h19, "wr_status_stop");
        reg_read(A_RX,     32'hA5, "wr_rx");
        reg_read(A_STATUS, 32'h11, "wr_status_rxread");
        reg_write(A_CMD, 32'h1);
        wait_cyc(2);
        check("wr_iack_irq_out", {31'h0, interrupt_o}, 32'h0);
        reg_read(A_STATUS, 32'h10, "wr_status_iack");

        // Read transaction
        reg_write(A_TX, 32'h3C);
        reg_read(A_STATUS, 32'h00, "rd_status_txfull");
        i2c_start();
        write_byte(8'h85, ack);
        check("rd_addr_ack", {31'h0, ack}, 32'h1);
        read_byte(d, 1'b0);
        check("rd_data", {24'h0, d}, 32'h3C);
        i2c_stop();
        wait_cyc(8);
        reg_read(A_STATUS, 32'h91, "rd_status");
        reg_write(A_CMD, 32'h1);

        // Address match / mismatch table
        for (int i = 0; i < 4; i++) begin
            i2c_start();
            write_byte(adr_tab[i].abyte, ack);
            check($sformatf("adr_ack_%0h", adr_tab[i].abyte), {31'h0, ack}, {31'h0, adr_tab[i].exp_ack});
            i2c_stop();
            wait_cyc(8);
            reg_read(A_STATUS, {24'h0, adr_tab[i].exp_stat}, $sformatf("adr_status_%0h", adr_tab[i].abyte));
            check($sformatf("adr_irq_out_%0h", adr_tab[i].abyte), {31'h0, interrupt_o},
                  {31'h0, adr_tab[i].exp_stat[0]});
            reg_write(A_CMD, 32'h1);
        end
        reg_read(A_RX, 32'hA5, "adr_rx_unchanged");

        // Overrun
        i2c_start();
        write_byte(8'h84, ack);
        check("ovr_addr_ack", {31'h0, ack}, 32'h1);
        write_byte(8'h11, ack);
        check("ovr_first_ack", {31'h0, ack}, 32'h1);
        write_byte(8'h22, ack);
        check("ovr_second_nack", {31'h0, ack}, 32'h0);
        i2c_stop();
        wait_cyc(8);
        reg_read(A_STATUS, 32'h1D, "ovr_status");
        reg_read(A_RX,     32'h11, "ovr_rx");
        reg_read(A_STATUS, 32'h15, "ovr_status_rxread");
        reg_write(A_CMD, 32'h2);
        reg_read(A_STATUS, 32'h11, "ovr_status_clr");
        reg_write(A_CMD, 32'h1);

        // Underrun with repeated START
        i2c_start();
        write_byte(8'h84, ack);
        check("unr_addr_w_ack", {31'h0, ack}, 32'h1);
        write_byte(8'h01, ack);
        check("unr_data_ack", {31'h0, ack}, 32'h1);
        i2c_start();
        write_byte(8'h85, ack);
        check("unr_addr_r_ack", {31'h0, ack}, 32'h1);
        read_byte(d, 1'b0);
        check("unr_data", {24'h0, d}, 32'hFF);
        i2c_stop();
        wait_cyc(8);
        reg_read(A_STATUS, 32'h9B, "unr_status");
        reg_read(A_RX,     32'h01, "unr_rx");
        reg_write(A_CMD, 32'h3);
        reg_read(A_STATUS, 32'h90, "unr_status_clr");

        // Reset while the slave is driving SDA low in the 4th data bit
        reg_write(A_TX, 32'h0F);
        i2c_start();
        write_byte(8'h85, ack);
        check("mrst_addr_ack", {31'h0, ack}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            read_bit(bit_v);
            check($sformatf("mrst_bit%0d", 7 - i), {31'h0, bit_v}, 32'h0);
        end
        wait_cyc(Q);
        m_sda = 1'b1;
        wait_cyc(HALF - Q);
        m_scl = 1'b1;
        wait_cyc(HALF / 2);
        check("mrst_pre_oen", {31'h0, sda_padoen_o}, 32'h0);
        check("mrst_pre_irq", {31'h0, interrupt_o}, 32'h1);
        rstn_i = 1'b1;
        @(negedge clk_i);
        rstn_i = 1'b0;
        check("mrst_post_oen", {31'h0, sda_padoen_o}, 32'h1);
        check("mrst_post_irq", {31'h0, interrupt_o}, 32'h0);
        check("mrst_post_rdata", avl_rdata, 32'h0);
        reg_read(A_STATUS, 32'h10, "mrst_status");

        wait_cyc(4);
        check("sb_drain", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
